// File: rtl/bcd_pkg.sv
// Shared BCD constants and the digit-clamping helper used by the counter and its digit stages.
package bcd_pkg;
    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic [3:0] bcd_sanitise(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle between the tick generator (master) and the BCD counter (slave).
interface bcd_updown_counter_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
);
    // Strobes (enable, load) are level-sampled on every rising clk edge; there is
    // no ready back-pressure, the counter accepts one request per cycle.
    logic                      enable;
    logic                      up;
    logic                      load;
    logic [BCD_W*DIGITS-1:0]   load_value;
    logic [BCD_W*DIGITS-1:0]   count;
    logic                      wrap;
    logic                      at_max;
    logic                      at_min;
    logic                      load_err;

    modport master (
        output enable, up, load, load_value,
        input  count, wrap, at_max, at_min, load_err
    );

    modport slave (
        input  enable, up, load, load_value,
        output count, wrap, at_max, at_min, load_err
    );
endinterface

// File: rtl/bcd_digit_stage.sv
// One BCD digit register; step_out is the carry (up) or borrow (down) into the next digit.
module bcd_digit_stage
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_in,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       step_out
);
    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       at_edge;

    assign at_edge  = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
    assign step_out = step_in & at_edge;
    assign digit    = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_sanitise(load_digit);
        end else if (step_in) begin
            if (up) begin
                digit_d = at_edge ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = at_edge ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end
endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit up/down BCD counter with sanitising parallel load, wrap/saturate mode and terminal flags.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_updown_counter_if.slave  bus
);
    localparam int W = BCD_W * DIGITS;

    logic [DIGITS:0] step;
    logic [W-1:0]    count_w;
    logic            at_max_w;
    logic            at_min_w;
    logic            sat_block;
    logic            bad_digit;
    logic            wrap_q;
    logic            wrap_d;
    logic            load_err_q;
    logic            load_err_d;

    assign at_max_w = (count_w == {DIGITS{BCD_MAX}});
    assign at_min_w = (count_w == '0);

    // In saturate mode a step at the boundary is dropped before it enters the chain,
    // so no carry can ever leave the top digit and wrap stays low.
    assign sat_block = (SATURATE != 0) && (bus.up ? at_max_w : at_min_w);
    assign step[0]   = bus.enable & ~bus.load & ~sat_block;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_stage u_stage (
            .clk        (clk),
            .rst        (rst),
            .step_in    (step[g]),
            .up         (bus.up),
            .load       (bus.load),
            .load_digit (bus.load_value[g*BCD_W +: BCD_W]),
            .digit      (count_w[g*BCD_W +: BCD_W]),
            .step_out   (step[g+1])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_value[i*BCD_W +: BCD_W] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
        // A carry out of the most significant digit means the whole count rolled over.
        wrap_d     = step[DIGITS];
        load_err_d = bus.load & bad_digit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_w;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.at_max   = at_max_w;
    assign bus.at_min   = at_min_w;
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised N-digit BCD counter, the successor to the fixed 3-digit up-only counter. Adds up/down counting, synchronous parallel load with digit sanitising, a wrap/saturate mode, and terminal-count status flags. It sits between the tick/enable generator and the 7-segment display drivers. It also serves as a cascadable event counter, through its wrap pulse.

Parameters:
DIGITS, 3, number of BCD digits (1..8); count width is 4*DIGITS
SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  count step request, sampled each rising edge
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load strobe
load_value  input  4*DIGITS  BCD load word, digit 0 in bits [3:0]
count  output  4*DIGITS  current BCD value, digit 0 = units
wrap  output  1  one-cycle pulse when the count wrapped (SATURATE=0 only)
at_max  output  1  count == all digits 9
at_min  output  1  count == all digits 0
load_err  output  1  one-cycle pulse: the last load contained a digit > 9

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. There is no asynchronous reset path.
- All outputs are registered or decoded from registers; no combinational path runs from the inputs to the outputs.
- Reset (rst=1 at a rising edge): count=0, wrap=0, load_err=0. The flags then decode to at_min=1, at_max=0. Reset overrides load and enable, and aborts any in-progress behaviour.
- Priority per edge: rst > load > enable. When neither load nor enable is asserted, count holds, wrap=0, load_err=0.
- Load: count <= load_value, taking effect at the next edge (1-cycle latency).
  - Any digit > 9 (values A-F) is replaced by 9.
  - load_err=1 for exactly that cycle.
  - wrap=0 on a load cycle. A load with enable also asserted performs no count step.
- Increment (enable=1, up=1): ripple-BCD add 1.
  - A digit at 9 becomes 0 and carries into the next digit; otherwise the digit gets +1.
- Decrement (enable=1, up=0): ripple-BCD subtract 1.
  - A digit at 0 becomes 9 and borrows from the next digit; otherwise the digit gets -1.
- Boundary at max going up, or at min going down:
  - SATURATE=0: count wraps to 0 (up) or to all-9s (down). wrap=1 for the same cycle in which count takes the wrapped value.
  - SATURATE=1: count holds and wrap stays 0.
- at_max and at_min are combinational decodes of count. They are valid from the cycle after reset onward.
- Direction may change on any cycle; each step uses the up value sampled on that edge.
- Consecutive enable cycles step every cycle. Full throughput is one step per clk.
- Stored digits are always 0-9; no illegal BCD state is reachable.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - function bcd_sanitise(digit), which returns min(digit, 9)
- Sub-module bcd_digit_stage: one digit register with inputs step_in, up, load, load_digit and output step_out (carry/borrow).
  - It is instantiated DIGITS times in a generate chain.
  - step_in of digit 0 = enable & ~load.
  - Top level handles wrap, saturate suppression (gated by at_max/at_min and up), and the flag decodes.

Test Plan:
- DIGITS=3: rst=1 for 2 cycles, then enable=1, up=1 for 1000 cycles. Required: count=000 after reset; steps 001, 002 … 999, 000. wrap pulses exactly once, on the cycle count returns to 000. at_max is high only while count=999.
- DIGITS=3, SATURATE=0: load 12'h000, then enable=1, up=0. Required: next count=999 with wrap=1 and at_max=1; then 998, with wrap=0.
- DIGITS=3, SATURATE=1: load 12'h998, then up=1 for 3 cycles. Required: count goes 999, 999, 999 with wrap always 0. Then up=0 gives 998.
- load_value=12'h1F9 with load=1 and enable=1 together. Required: count=199 next cycle, load_err=1 for one cycle, no extra step.
- count=057 counting up, rst=1 asserted together with load=1 and enable=1. Required: count=000 on the next edge, with wrap=0 and load_err=0.
- DIGITS=1: enable=1, toggle up every cycle starting from 5. Required: sequence 6, 5, 6, 5. Then up=1 from 9 gives 0 with wrap=1.
